// File: rtl/bridge_pkg.sv
// Shared types and canonical switch patterns for the H-bridge gate-drive interlock.
// A pattern holds four top and four bottom switch bits; bit i drives leg i.
package bridge_pkg;

    typedef enum logic [1:0] {
        S_OFF,
        S_DEAD,
        S_ON
    } bridge_state_t;

    typedef struct packed {
        bit [4:1] top;
        bit [4:1] bot;
    } leg_pattern_t;

    localparam leg_pattern_t PAT_OFF   = leg_pattern_t'({4'b0000, 4'b0000});
    localparam leg_pattern_t PAT_PLUS  = leg_pattern_t'({4'b0001, 4'b0010});
    localparam leg_pattern_t PAT_MINUS = leg_pattern_t'({4'b0010, 4'b0001});
    localparam leg_pattern_t PAT_BALP  = leg_pattern_t'({4'b0100, 4'b1000});
    localparam leg_pattern_t PAT_BALN  = leg_pattern_t'({4'b1000, 4'b0100});

    // A pattern is a shoot-through hazard if any leg has both switches closed.
    function automatic logic pat_illegal(input leg_pattern_t p);
        return |(p.top & p.bot);
    endfunction

endpackage

// File: rtl/bridge_deadtime.sv
// Gate-drive interlock: break-before-make dead time, minimum on-time,
// shoot-through rejection and a kill path, all with registered outputs.
module bridge_deadtime
    import bridge_pkg::*;
#(
    parameter int unsigned FREQ         = 50_000_000,
    parameter int unsigned DEADTIME_CYC = 100,
    parameter int unsigned MIN_ON_CYC   = 500,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_top,
    input  logic [3:0] req_bot,
    input  logic       kill,
    output logic [3:0] o_top,
    output logic [3:0] o_bot,
    output logic       busy,
    output logic       err_shoot
);

    if (FREQ < 1 || DEADTIME_CYC < 1 || MIN_ON_CYC < 1 ||
        longint'(DEADTIME_CYC) >= (64'd1 << CNT_W) ||
        longint'(MIN_ON_CYC) >= (64'd1 << CNT_W)) begin : g_bad_param
        $error("bridge_deadtime: invalid timing parameters");
    end

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME_CYC - 1);
    localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(MIN_ON_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef struct packed {
        bridge_state_t    state;
        leg_pattern_t     applied;
        leg_pattern_t     drive;
        logic             busy;
        logic             err;
        logic [CNT_W-1:0] on_cnt;
        logic [CNT_W-1:0] dead_cnt;
        logic             ill_prev;
        leg_pattern_t     req_prev;
    } state_t;

    state_t       r_st;
    state_t       w_st_next;
    leg_pattern_t w_req;
    leg_pattern_t w_target;
    logic         w_illegal;

    always_comb begin
        w_req     = leg_pattern_t'({req_top, req_bot});
        w_illegal = pat_illegal(w_req);
        w_target  = w_illegal ? PAT_OFF : w_req;

        w_st_next          = r_st;
        // Pulse on a fresh illegal request or a different illegal value.
        w_st_next.err      = w_illegal && (!r_st.ill_prev || (w_req != r_st.req_prev));
        w_st_next.ill_prev = w_illegal;
        w_st_next.req_prev = w_req;

        if (kill) begin
            w_st_next.state    = S_DEAD;
            w_st_next.dead_cnt = DEAD_LOAD;
        end else begin
            case (r_st.state)
                S_OFF: begin
                    if (w_target != PAT_OFF) begin
                        w_st_next.state   = S_ON;
                        w_st_next.applied = w_target;
                        w_st_next.on_cnt  = ON_LOAD;
                    end
                end
                S_ON: begin
                    // A pending change is never latched; the live target is compared once on_cnt expires.
                    if (r_st.on_cnt == '0) begin
                        if (w_target != r_st.applied) begin
                            w_st_next.state    = S_DEAD;
                            w_st_next.dead_cnt = DEAD_LOAD;
                        end
                    end else begin
                        w_st_next.on_cnt = r_st.on_cnt - CNT_ONE;
                    end
                end
                S_DEAD: begin
                    if (r_st.dead_cnt == '0) begin
                        if (w_target != PAT_OFF) begin
                            w_st_next.state   = S_ON;
                            w_st_next.applied = w_target;
                            w_st_next.on_cnt  = ON_LOAD;
                        end else begin
                            w_st_next.state = S_OFF;
                        end
                    end else begin
                        w_st_next.dead_cnt = r_st.dead_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_st_next.state    = S_DEAD;
                    w_st_next.dead_cnt = DEAD_LOAD;
                end
            endcase
        end

        w_st_next.drive = (w_st_next.state == S_ON) ? w_st_next.applied : PAT_OFF;
        w_st_next.busy  = (w_st_next.state == S_DEAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st.state    <= S_DEAD;
            r_st.applied  <= PAT_OFF;
            r_st.drive    <= PAT_OFF;
            r_st.busy     <= 1'b1;
            r_st.err      <= 1'b0;
            r_st.on_cnt   <= '0;
            r_st.dead_cnt <= DEAD_LOAD;
            r_st.ill_prev <= 1'b0;
            r_st.req_prev <= PAT_OFF;
        end else begin
            r_st <= w_st_next;
        end
    end

    assign o_top     = r_st.drive.top;
    assign o_bot     = r_st.drive.bot;
    assign busy      = r_st.busy;
    assign err_shoot = r_st.err;

endmodule

// File: tb/tb_bridge_deadtime.sv
// Directed plus randomized bench for bridge_deadtime against a cycle-level
// reference model expressed as zero-run length and on-age bookkeeping.
module tb_bridge_deadtime;

    localparam int DEAD   = 4;
    localparam int MIN_ON = 8;

    localparam logic [7:0] P_OFF   = 8'b0000_0000;
    localparam logic [7:0] P_PLUS  = 8'b0001_0010;
    localparam logic [7:0] P_MINUS = 8'b0010_0001;
    localparam logic [7:0] P_BALP  = 8'b0100_1000;
    localparam logic [7:0] P_BALN  = 8'b1000_0100;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_top;
    logic [3:0] req_bot;
    logic       kill;
    logic [3:0] o_top;
    logic [3:0] o_bot;
    logic       busy;
    logic       err_shoot;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_out;
    int         m_gap;
    int         m_age;
    logic       m_ill_prev;
    logic [7:0] m_req_prev;
    logic       m_err;

    bridge_deadtime #(
        .FREQ        (50_000_000),
        .DEADTIME_CYC(DEAD),
        .MIN_ON_CYC  (MIN_ON),
        .CNT_W       (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_top  (req_top),
        .req_bot  (req_bot),
        .kill     (kill),
        .o_top    (o_top),
        .o_bot    (o_bot),
        .busy     (busy),
        .err_shoot(err_shoot)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out      = P_OFF;
        m_gap      = 0;
        m_age      = 0;
        m_ill_prev = 1'b0;
        m_req_prev = 8'h00;
        m_err      = 1'b0;
    endtask

    // Outputs stay zero until DEAD zero cycles have elapsed; a pattern is kept
    // at least MIN_ON cycles; kill zeroes outputs and restarts the zero count.
    task automatic model_step();
        logic [7:0] rq;
        logic [7:0] tgt;
        logic       ill;
        rq  = {req_top, req_bot};
        ill = |(req_top & req_bot);
        tgt = ill ? 8'h00 : rq;
        m_err      = ill && (!m_ill_prev || rq != m_req_prev);
        m_ill_prev = ill;
        m_req_prev = rq;
        if (kill) begin
            m_out = P_OFF;
            m_gap = 0;
            m_age = 0;
        end else if (m_out != P_OFF) begin
            if (tgt != m_out && m_age >= MIN_ON) begin
                m_out = P_OFF;
                m_gap = 0;
            end else if (m_age < MIN_ON) begin
                m_age++;
            end
        end else begin
            if (m_gap + 1 >= DEAD && tgt != P_OFF) begin
                m_out = tgt;
                m_age = 1;
            end else if (m_gap < DEAD) begin
                m_gap++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_busy;
        exp_busy = (m_out == P_OFF) && (m_gap < DEAD);
        chk({tag, "_top"},   {4'h0, o_top},        {4'h0, m_out[7:4]});
        chk({tag, "_bot"},   {4'h0, o_bot},        {4'h0, m_out[3:0]});
        chk({tag, "_busy"},  {7'h0, busy},         {7'h0, exp_busy});
        chk({tag, "_err"},   {7'h0, err_shoot},    {7'h0, m_err});
        chk({tag, "_shoot"}, {4'h0, o_top & o_bot}, 8'h00);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_outputs("cyc");
    endtask

    // Counts consecutive observations equal to pat, starting with the current one.
    task automatic count_while(input logic [7:0] pat, input int maxc, output int n);
        n = 0;
        while ({o_top, o_bot} === pat && n < maxc) begin
            n++;
            cycle();
        end
    endtask

    task automatic async_reset(input int hold);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("rst");
        repeat (hold) cycle();
        rst = 1'b0;
    endtask

    task automatic set_req(input logic [7:0] p);
        {req_top, req_bot} = p;
    endtask

    initial begin
        int n;
        int n_on;
        int sel;
        int hold;
        int k;
        logic [7:0] rp;

        rst  = 1'b1;
        kill = 1'b0;
        set_req(P_PLUS);
        model_reset();
        #2;
        check_outputs("reset");
        repeat (2) cycle();
        rst = 1'b0;

        // 1: full dead window after reset, then PLUS
        count_while(P_OFF, 20, n);
        chk("t1_dead_len", 8'(n), 8'd4);
        chk("t1_pattern", {o_top, o_bot}, P_PLUS);
        chk("t1_busy", {7'h0, busy}, 8'h00);

        // 2: long-held PLUS then MINUS
        repeat (19) cycle();
        set_req(P_MINUS);
        count_while(P_PLUS, 20, n);
        chk("t2_plus_tail", 8'(n), 8'd1);
        count_while(P_OFF, 20, n);
        chk("t2_dead_len", 8'(n), 8'd4);
        chk("t2_pattern", {o_top, o_bot}, P_MINUS);

        // 3: change requested early is held until min on-time
        set_req(P_PLUS);
        count_while(P_MINUS, 40, n);
        count_while(P_OFF, 40, n);
        chk("t3_plus_on", {o_top, o_bot}, P_PLUS);
        cycle();
        set_req(P_MINUS);
        count_while(P_PLUS, 40, n_on);
        chk("t3_min_on", 8'(n_on + 1), 8'd8);
        count_while(P_OFF, 20, n);
        chk("t3_dead_len", 8'(n), 8'd4);
        chk("t3_pattern", {o_top, o_bot}, P_MINUS);

        // 4: shoot-through request
        set_req(8'b0001_0001);
        cycle();
        chk("t4_err_pulse", {7'h0, err_shoot}, 8'h01);
        cycle();
        chk("t4_err_clear", {7'h0, err_shoot}, 8'h00);
        repeat (20) cycle();
        chk("t4_outputs_off", {o_top, o_bot}, P_OFF);

        // 5: kill during BALP
        set_req(P_BALP);
        count_while(P_OFF, 40, n);
        chk("t5_balp_on", {o_top, o_bot}, P_BALP);
        repeat (5) cycle();
        kill = 1'b1;
        cycle();
        chk("t5_kill_off", {o_top, o_bot}, P_OFF);
        repeat (2) cycle();
        kill = 1'b0;
        count_while(P_OFF, 20, n);
        chk("t5_after_kill", 8'(n), 8'd4);
        chk("t5_balp_back", {o_top, o_bot}, P_BALP);

        // 6: reset mid dead window and mid on-time
        set_req(P_BALN);
        count_while(P_BALP, 40, n);
        cycle();
        async_reset(2);
        count_while(P_OFF, 20, n);
        chk("t6_dead_rst_len", 8'(n), 8'd4);
        chk("t6_baln_a", {o_top, o_bot}, P_BALN);
        repeat (3) cycle();
        async_reset(1);
        count_while(P_OFF, 20, n);
        chk("t6_on_rst_len", 8'(n), 8'd4);
        chk("t6_baln_b", {o_top, o_bot}, P_BALN);

        // Randomized phase
        for (int it = 0; it < 300; it++) begin
            sel  = $urandom_range(0, 11);
            hold = $urandom_range(1, 14);
            case (sel)
                0: set_req(P_OFF);
                1: set_req(P_PLUS);
                2: set_req(P_MINUS);
                3: set_req(P_BALP);
                4: set_req(P_BALN);
                5, 6: begin
                    k  = $urandom_range(0, 3);
                    rp = 8'($urandom);
                    rp[4 + k] = 1'b1;
                    rp[k]     = 1'b1;
                    set_req(rp);
                end
                7, 8: set_req(8'($urandom));
                9: begin
                    kill = 1'b1;
                    hold = $urandom_range(1, 3);
                end
                10: begin
                    async_reset($urandom_range(1, 2));
                    hold = 1;
                end
                default: ;
            endcase
            repeat (hold) cycle();
            kill = 1'b0;
        end
        repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
